// File: rtl/timer_bank.sv
// timer_bank: memory-mapped bank of N_CH independent 32-bit down-counting
// timers behind the word-addressed device bus.
//
// Each channel owns four word registers starting at BASE_ADDR + 16*ch:
//   +0 CTRL   [0] EN, [2:1] MODE, [3] IM   (MODE 0 one-shot, 1 auto-reload,
//                                            2 cascade, 3 behaves as one-shot)
//   +4 PRESET reload value
//   +8 COUNT  current count, read-only
//   +C STATUS [0] PEND, sticky, write 1 to clear
// In cascade mode a channel only advances on the cycles where its lower
// neighbour hits zero; channel 0 has no neighbour and never advances.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   addr     byte address from the bridge (addr[1:0] ignored)
//   we       write strobe, qualified by an address hit
//   wd       write data
//   rd       read data, combinational from addr (0 on a miss)
//   irq      per-channel interrupt, PEND & IM
//   irq_any  OR of irq
module timer_bank #(
  parameter int          N_CH      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h00007f00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);

  localparam int          CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [32:0] SPAN = 33'(16 * N_CH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2
  } state_t;

  state_t          state  [N_CH];
  logic [1:0]      mode   [N_CH];
  logic [31:0]     preset [N_CH];
  logic [31:0]     count  [N_CH];
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] im;
  logic [N_CH-1:0] pend;

  // Address decode. The 33-bit difference borrows into bit 32 when addr is
  // below BASE_ADDR, so a single compare covers both ends of the window.
  logic [32:0]     off;
  logic            hit;
  logic [CH_W-1:0] sel_ch;
  logic [1:0]      sel_reg;

  assign off     = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign hit     = !off[32] && (off < SPAN);
  assign sel_ch  = off[4 +: CH_W];
  assign sel_reg = addr[3:2];

  logic [N_CH-1:0] ctrl_wr;
  logic [N_CH-1:0] preset_wr;
  logic [N_CH-1:0] status_wr;

  always_comb begin
    ctrl_wr   = '0;
    preset_wr = '0;
    status_wr = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (we && hit && (sel_ch == CH_W'(i))) begin
        case (sel_reg)
          2'd0:    ctrl_wr[i]   = 1'b1;
          2'd1:    preset_wr[i] = 1'b1;
          2'd3:    status_wr[i] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Per-channel advance and zero-event logic. The cascade tick is taken from
  // the neighbouring generate block so the chain is a plain wire path from
  // channel 0 upward. A CTRL write takes over the channel for that cycle, so
  // no zero event (and no PEND set or neighbour tick) is produced then.
  logic [N_CH-1:0] act_v;
  logic [N_CH-1:0] zero_evt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic tick;
    logic act;
    logic zero;

    if (g == 0) begin : g_first
      assign tick = 1'b0;
    end else begin : g_link
      assign tick = g_ch[g-1].zero;
    end

    assign act  = (state[g] == CNT) && !ctrl_wr[g] && ((mode[g] != 2'd2) || tick);
    assign zero = act && (count[g] == 32'd0);

    assign act_v[g]    = act;
    assign zero_evt[g] = zero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state[i]  <= IDLE;
        mode[i]   <= 2'd0;
        preset[i] <= 32'd0;
        count[i]  <= 32'd0;
      end
      en   <= '0;
      im   <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        // A CTRL write overrides whatever the channel was doing, so the
        // sequencer is held off for that cycle and COUNT stays frozen.
        if (!ctrl_wr[i]) begin
          case (state[i])
            IDLE: ;
            LOAD: begin
              count[i] <= preset[i];
              state[i] <= CNT;
            end
            CNT: begin
              if (act_v[i]) begin
                if (count[i] != 32'd0) begin
                  count[i] <= count[i] - 32'd1;
                end else if ((mode[i] == 2'd1) || (mode[i] == 2'd2)) begin
                  state[i] <= LOAD;
                end else begin
                  en[i]    <= 1'b0;
                  state[i] <= IDLE;
                end
              end
            end
            default: state[i] <= IDLE;
          endcase
        end else begin
          en[i]    <= wd[0];
          mode[i]  <= wd[2:1];
          im[i]    <= wd[3];
          state[i] <= wd[0] ? LOAD : IDLE;
        end

        if (preset_wr[i]) begin
          preset[i] <= wd;
        end

        // A zero event in the same cycle as a clear leaves PEND set.
        if (zero_evt[i]) begin
          pend[i] <= 1'b1;
        end else if (status_wr[i] && wd[0]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd = 32'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (hit && (sel_ch == CH_W'(i))) begin
        case (sel_reg)
          2'd0:    rd = {28'd0, im[i], mode[i], en[i]};
          2'd1:    rd = preset[i];
          2'd2:    rd = count[i];
          default: rd = {31'd0, pend[i]};
        endcase
      end
    end
  end

  assign irq     = pend & im;
  assign irq_any = |irq;

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised, memory-mapped bank of N_CH independent 32-bit down-counting timers.
- Attaches behind the bridge on the word-addressed device bus.
- Successor to the fixed two-instance timer pair. Adds:
  - channel-count and base-address parameters;
  - sticky write-1-to-clear status;
  - per-channel interrupt mask;
  - a cascade mode in which a channel counts the zero events of its lower neighbour.
- irq[] feeds the CP0 hardware-interrupt inputs.

Parameters:
- N_CH, 4, number of timer channels (1..8).
- BASE_ADDR, 32'h00007f00, byte address of channel 0. Channel i occupies BASE_ADDR + 16*i .. +15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from bridge; addr[1:0] ignored.
- we  input  1  write strobe, qualified by address hit.
- wd  input  32  write data.
- rd  output  32  read data, combinational from addr.
- irq  output  N_CH  per-channel interrupt, = pending[i] & IM[i].
- irq_any  output  1  OR of irq.

Behaviour:

Address decode:
- hit = BASE_ADDR <= addr < BASE_ADDR + 16*N_CH.
- ch = (addr - BASE_ADDR) >> 4. reg = addr[3:2].
- Miss: rd = 0; writes ignored.

Register map (per channel):
- 0 CTRL: [0] EN, [2:1] MODE, [3] IM, [31:4] read 0.
- 1 PRESET: rw 32.
- 2 COUNT: read-only; writes ignored.
- 3 STATUS: [0] PEND, read; writing 1 to bit 0 clears it; others read 0.

MODE:
- 0: one-shot.
- 1: auto-reload.
- 2: cascade.
- 3: treated as 0.

Reset (reset low, async):
- All CTRL, PRESET, COUNT, PEND = 0. State IDLE.
- irq = 0, irq_any = 0. rd is 0 for every hit address.

Per-channel FSM (IDLE, LOAD, CNT):
- IDLE: COUNT holds. A CTRL write with wd[0]=1 -> LOAD.
- LOAD: COUNT <= PRESET -> CNT.
- CNT, action enabled (always in modes 0/1/3; in mode 2 only when tick_in = zero_evt of ch-1):
  - COUNT>0: COUNT <= COUNT-1.
  - COUNT==0: zero_evt=1 for this cycle, PEND <= 1. Then:
    - mode 0/3: EN <= 0, -> IDLE.
    - mode 1/2: -> LOAD.
- CNT, action not enabled: hold.
- Channel 0 in mode 2: tick_in = 0; it never advances.

Latency:
- CTRL write (EN=1) in cycle t: LOAD in t+1, first CNT in t+2.
- PEND visible from cycle t+PRESET+3.
- Auto-reload period = PRESET+2 cycles.

Bus interaction with a running channel:
- CTRL write with EN=0 in any state: -> IDLE next edge; COUNT frozen; PEND unchanged.
- CTRL write with EN=1 in any state: restart via LOAD (MODE/IM updated same edge).
- PRESET write during CNT: COUNT unaffected; new value used at next LOAD.
- PRESET written in the same cycle as LOAD: LOAD uses the old PRESET.
- Same cycle PEND set and STATUS W1C: set wins.
- IM=0 suppresses irq only; PEND still sets.
- IM later set with PEND=1: irq asserts next cycle.

Arithmetic and outputs:
- COUNT is unsigned 32-bit; it never wraps below 0.
- PRESET = 32'hffffffff is legal.
- irq and irq_any are registered-derived (from PEND/IM flops); glitch-free.
- Reset asserted mid-count: immediate return to reset values. Counting resumes only after a new CTRL write.

Test Plan:
- Reset/readback: after reset, read all 4*N_CH addresses -> 0. Write PRESET ch1 = 32'h1234 -> read 32'h1234. Read addr 32'h00007f40 with N_CH=4 -> 0 (miss).
- One-shot: ch0 PRESET=5, CTRL=32'h9 at cycle 0.
  - Required: COUNT=5 at cycle 2, =0 at cycle 7; PEND, irq[0], irq_any =1 at cycle 8; CTRL reads 32'h8; COUNT stays 0.
  - STATUS write 1 -> irq[0]=0 next cycle.
- Auto-reload with mask off: ch2 PRESET=3, CTRL=32'h3.
  - Required: PEND first at cycle 6; COUNT cycles 3,2,1,0 then reloads with period 5; irq[2] stays 0.
  - Then set IM -> irq[2]=1 next cycle.
- Cascade: ch0 mode1 PRESET=1; ch1 mode2 PRESET=2; both enabled same cycle.
  - Required: ch1 decrements once per ch0 zero event (every 3 cycles); ch1 PEND after 3 ch0 zero events.
- Races: W1C on the cycle ch0 reaches zero -> PEND remains 1. CTRL EN=0 write mid-count at COUNT=4 -> COUNT holds 4, no irq. Assert reset at COUNT=2 -> all zero immediately, irq never rises.
